// File: rtl/servant_spi_mem_arbiter.sv
// Two-requester Wishbone arbiter in front of the SPI memory master.
// Serialises CPU and aux accesses, holds each grant until ack, and aborts hung transfers.
module servant_spi_mem_arbiter #(
  parameter bit          ROUND_ROBIN = 1'b1,
  parameter int unsigned TIMEOUT     = 4096,
  parameter logic [31:0] ERR_DATA    = 32'hFFFF_FFFF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_wb_cpu_adr,
  input  logic [31:0] i_wb_cpu_dat,
  input  logic [3:0]  i_wb_cpu_sel,
  input  logic        i_wb_cpu_we,
  input  logic        i_wb_cpu_cyc,
  output logic [31:0] o_wb_cpu_rdt,
  output logic        o_wb_cpu_ack,
  input  logic [31:0] i_wb_aux_adr,
  input  logic [31:0] i_wb_aux_dat,
  input  logic [3:0]  i_wb_aux_sel,
  input  logic        i_wb_aux_we,
  input  logic        i_wb_aux_cyc,
  output logic [31:0] o_wb_aux_rdt,
  output logic        o_wb_aux_ack,
  output logic [31:0] o_wb_spi_adr,
  output logic [31:0] o_wb_spi_dat,
  output logic [3:0]  o_wb_spi_sel,
  output logic        o_wb_spi_we,
  output logic        o_wb_spi_cyc,
  input  logic [31:0] i_wb_spi_rdt,
  input  logic        i_wb_spi_ack,
  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  localparam int unsigned    CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  LAST_CNT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          owner;       // 0 = cpu, 1 = aux
  logic          last_grant;
  logic          pick_aux;
  logic          done;
  logic [31:0]   done_rdt;

  // On a tie, round robin hands the bus to whoever did not have it last.
  always_comb begin
    pick_aux = i_wb_aux_cyc && (!i_wb_cpu_cyc || (ROUND_ROBIN && !last_grant));
    done     = (state == ACTIVE) && (i_wb_spi_ack || (count == LAST_CNT));
    done_rdt = i_wb_spi_ack ? i_wb_spi_rdt : ERR_DATA;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      count        <= '0;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      o_wb_cpu_rdt <= '0;
      o_wb_cpu_ack <= 1'b0;
      o_wb_aux_rdt <= '0;
      o_wb_aux_ack <= 1'b0;
      o_wb_spi_adr <= '0;
      o_wb_spi_dat <= '0;
      o_wb_spi_sel <= '0;
      o_wb_spi_we  <= 1'b0;
      o_wb_spi_cyc <= 1'b0;
      o_grant      <= '0;
      o_timeout    <= 1'b0;
    end else begin
      o_wb_cpu_ack <= 1'b0;
      o_wb_aux_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_wb_cpu_cyc || i_wb_aux_cyc) begin
            owner        <= pick_aux;
            last_grant   <= pick_aux;
            o_wb_spi_adr <= pick_aux ? i_wb_aux_adr : i_wb_cpu_adr;
            o_wb_spi_dat <= pick_aux ? i_wb_aux_dat : i_wb_cpu_dat;
            o_wb_spi_sel <= pick_aux ? i_wb_aux_sel : i_wb_cpu_sel;
            o_wb_spi_we  <= pick_aux ? i_wb_aux_we  : i_wb_cpu_we;
            o_wb_spi_cyc <= 1'b1;
            o_grant      <= pick_aux ? 2'b10 : 2'b01;
            count        <= '0;
            state        <= ACTIVE;
          end
        end
        ACTIVE: begin
          count <= count + CW'(1);
          if (done) begin
            if (owner) begin
              o_wb_aux_rdt <= done_rdt;
              o_wb_aux_ack <= 1'b1;
            end else begin
              o_wb_cpu_rdt <= done_rdt;
              o_wb_cpu_ack <= 1'b1;
            end
            if (!i_wb_spi_ack) o_timeout <= 1'b1;
            o_wb_spi_cyc <= 1'b0;
            state        <= RELEASE;
          end
        end
        RELEASE: begin
          count   <= '0;
          o_grant <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servant_spi_mem_arbiter.sv
// Bench for servant_spi_mem_arbiter: two instances (round robin and fixed priority),
// a per-cycle transaction model per instance, plus literal expectations per scenario.
module tb_servant_spi_mem_arbiter;

  localparam int unsigned TO = 16;

  logic        clk;
  logic        rst_n   [2];
  // requester signals indexed [instance][requester], requester 0 = cpu, 1 = aux
  logic [31:0] r_adr   [2][2];
  logic [31:0] r_dat   [2][2];
  logic [3:0]  r_sel   [2][2];
  logic        r_we    [2][2];
  logic        r_cyc   [2][2];
  logic [31:0] r_rdt   [2][2];
  logic        r_ack   [2][2];
  logic [31:0] spi_adr [2];
  logic [31:0] spi_dat [2];
  logic [3:0]  spi_sel [2];
  logic        spi_we  [2];
  logic        spi_cyc [2];
  logic [31:0] spi_rdt [2];
  logic        spi_ack [2];
  logic [1:0]  grant   [2];
  logic        tflag   [2];

  int n_checks = 0;
  int n_pass   = 0;

  servant_spi_mem_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT(TO), .ERR_DATA(32'hFFFF_FFFF)) dut_rr (
    .i_clk(clk), .i_rst_n(rst_n[0]),
    .i_wb_cpu_adr(r_adr[0][0]), .i_wb_cpu_dat(r_dat[0][0]), .i_wb_cpu_sel(r_sel[0][0]),
    .i_wb_cpu_we(r_we[0][0]), .i_wb_cpu_cyc(r_cyc[0][0]), .o_wb_cpu_rdt(r_rdt[0][0]),
    .o_wb_cpu_ack(r_ack[0][0]),
    .i_wb_aux_adr(r_adr[0][1]), .i_wb_aux_dat(r_dat[0][1]), .i_wb_aux_sel(r_sel[0][1]),
    .i_wb_aux_we(r_we[0][1]), .i_wb_aux_cyc(r_cyc[0][1]), .o_wb_aux_rdt(r_rdt[0][1]),
    .o_wb_aux_ack(r_ack[0][1]),
    .o_wb_spi_adr(spi_adr[0]), .o_wb_spi_dat(spi_dat[0]), .o_wb_spi_sel(spi_sel[0]),
    .o_wb_spi_we(spi_we[0]), .o_wb_spi_cyc(spi_cyc[0]), .i_wb_spi_rdt(spi_rdt[0]),
    .i_wb_spi_ack(spi_ack[0]), .o_grant(grant[0]), .o_timeout(tflag[0]));

  servant_spi_mem_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT(TO), .ERR_DATA(32'hFFFF_FFFF)) dut_fp (
    .i_clk(clk), .i_rst_n(rst_n[1]),
    .i_wb_cpu_adr(r_adr[1][0]), .i_wb_cpu_dat(r_dat[1][0]), .i_wb_cpu_sel(r_sel[1][0]),
    .i_wb_cpu_we(r_we[1][0]), .i_wb_cpu_cyc(r_cyc[1][0]), .o_wb_cpu_rdt(r_rdt[1][0]),
    .o_wb_cpu_ack(r_ack[1][0]),
    .i_wb_aux_adr(r_adr[1][1]), .i_wb_aux_dat(r_dat[1][1]), .i_wb_aux_sel(r_sel[1][1]),
    .i_wb_aux_we(r_we[1][1]), .i_wb_aux_cyc(r_cyc[1][1]), .o_wb_aux_rdt(r_rdt[1][1]),
    .o_wb_aux_ack(r_ack[1][1]),
    .o_wb_spi_adr(spi_adr[1]), .o_wb_spi_dat(spi_dat[1]), .o_wb_spi_sel(spi_sel[1]),
    .o_wb_spi_we(spi_we[1]), .o_wb_spi_cyc(spi_cyc[1]), .i_wb_spi_rdt(spi_rdt[1]),
    .i_wb_spi_ack(spi_ack[1]), .o_grant(grant[1]), .o_timeout(tflag[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s[dut%0d] got %h want %h at %0t", name, d, act, exp, $time);
    else n_pass++;
  endtask

  // Slave responder: acks once, lat cycles after cyc is first seen (lat 0 = never).
  int          slave_lat  [2];
  logic [31:0] slave_data [2];
  logic        extra_ack  [2];
  int          sn         [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic a;
      a = 1'b0;
      if (spi_cyc[d] === 1'b1) begin
        sn[d]++;
        a = (slave_lat[d] != 0) && (sn[d] == slave_lat[d]);
      end else sn[d] = 0;
      spi_ack[d] = a | extra_ack[d];
      spi_rdt[d] = slave_data[d];
    end
  end

  // Transaction model: who owns the bus, how long it has been out, and whether it has finished.
  int          m_owner [2];
  int          m_age   [2];
  int          m_last  [2];
  bit          m_done  [2];
  bit          m_to    [2];
  bit          m_ack   [2][2];
  logic [31:0] m_rdt   [2][2];
  logic [31:0] m_adr   [2];
  logic [31:0] m_dat   [2];
  logic [3:0]  m_sel   [2];
  logic        m_we    [2];

  function automatic void model_step(int d);
    int pick;
    m_ack[d][0] = 1'b0;
    m_ack[d][1] = 1'b0;
    if (!rst_n[d]) begin
      m_owner[d] = -1; m_age[d] = 0; m_last[d] = 1; m_done[d] = 1'b0; m_to[d] = 1'b0;
      m_rdt[d][0] = '0; m_rdt[d][1] = '0;
      m_adr[d] = '0; m_dat[d] = '0; m_sel[d] = '0; m_we[d] = 1'b0;
    end else if (m_owner[d] < 0) begin
      pick = -1;
      if (r_cyc[d][0] && r_cyc[d][1]) pick = (d == 0 && m_last[d] == 0) ? 1 : 0;
      else if (r_cyc[d][0]) pick = 0;
      else if (r_cyc[d][1]) pick = 1;
      if (pick >= 0) begin
        m_owner[d] = pick; m_last[d] = pick; m_age[d] = 0; m_done[d] = 1'b0;
        m_adr[d] = r_adr[d][pick]; m_dat[d] = r_dat[d][pick];
        m_sel[d] = r_sel[d][pick]; m_we[d] = r_we[d][pick];
      end
    end else if (m_done[d]) begin
      m_owner[d] = -1;
    end else begin
      m_age[d]++;
      if (spi_ack[d]) begin
        m_rdt[d][m_owner[d]] = spi_rdt[d];
        m_ack[d][m_owner[d]] = 1'b1;
        m_done[d] = 1'b1;
      end else if (m_age[d] == TO) begin
        m_rdt[d][m_owner[d]] = 32'hFFFF_FFFF;
        m_ack[d][m_owner[d]] = 1'b1;
        m_to[d] = 1'b1;
        m_done[d] = 1'b1;
      end
    end
  endfunction

  // Grant log and cyc run-length, used by the literal checks.
  logic [1:0]  lg_grant [2][64];
  logic [31:0] lg_adr   [2][64];
  logic [31:0] lg_dat   [2][64];
  logic        lg_we    [2][64];
  int          log_n    [2];
  int          runlen   [2];
  int          last_run [2];
  logic        prev_cyc [2];
  int          ack_cnt  [2][2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) model_step(d);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("spi_cyc", d, 32'(spi_cyc[d]), 32'(m_owner[d] >= 0 && !m_done[d]));
      chk("grant",   d, 32'(grant[d]),   (m_owner[d] < 0) ? 32'd0 : (m_owner[d] == 0 ? 32'd1 : 32'd2));
      chk("spi_adr", d, spi_adr[d], m_adr[d]);
      chk("spi_dat", d, spi_dat[d], m_dat[d]);
      chk("spi_sel", d, 32'(spi_sel[d]), 32'(m_sel[d]));
      chk("spi_we",  d, 32'(spi_we[d]),  32'(m_we[d]));
      chk("timeout", d, 32'(tflag[d]),   32'(m_to[d]));
      for (int r = 0; r < 2; r++) begin
        chk(r == 0 ? "cpu_ack" : "aux_ack", d, 32'(r_ack[d][r]), 32'(m_ack[d][r]));
        chk(r == 0 ? "cpu_rdt" : "aux_rdt", d, r_rdt[d][r], m_rdt[d][r]);
        if (r_ack[d][r] === 1'b1) ack_cnt[d][r]++;
      end
      if (spi_cyc[d] === 1'b1) begin
        if (prev_cyc[d] !== 1'b1 && log_n[d] < 64) begin
          lg_grant[d][log_n[d]] = grant[d];
          lg_adr[d][log_n[d]]   = spi_adr[d];
          lg_dat[d][log_n[d]]   = spi_dat[d];
          lg_we[d][log_n[d]]    = spi_we[d];
          log_n[d]++;
        end
        runlen[d]++;
      end else begin
        if (prev_cyc[d] === 1'b1) last_run[d] = runlen[d];
        runlen[d] = 0;
      end
      prev_cyc[d] = spi_cyc[d];
    end
  end

  task automatic access(input int d, input int r, input logic [31:0] adr, input logic [31:0] dat,
                        input logic we, input bit keep);
    bit got;
    got = 1'b0;
    @(negedge clk);
    r_adr[d][r] = adr; r_dat[d][r] = dat; r_sel[d][r] = 4'hF; r_we[d][r] = we; r_cyc[d][r] = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (r_ack[d][r] === 1'b1) got = 1'b1;
    end
    if (!got) chk("ack_wait", d, 32'd0, 32'd1);
    if (!keep) r_cyc[d][r] = 1'b0;
  endtask

  task automatic apply_reset(input int d);
    @(negedge clk);
    rst_n[d] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n[d] = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    int acks;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; slave_lat[d] = 0; slave_data[d] = '0; extra_ack[d] = 1'b0;
      spi_ack[d] = 1'b0; spi_rdt[d] = '0; sn[d] = 0; log_n[d] = 0; runlen[d] = 0;
      last_run[d] = 0; prev_cyc[d] = 1'b0;
      m_owner[d] = -1; m_done[d] = 1'b0; m_to[d] = 1'b0; m_last[d] = 1; m_age[d] = 0;
      for (int r = 0; r < 2; r++) begin
        r_adr[d][r] = '0; r_dat[d][r] = '0; r_sel[d][r] = '0; r_we[d][r] = 1'b0;
        r_cyc[d][r] = 1'b0; ack_cnt[d][r] = 0; m_ack[d][r] = 1'b0; m_rdt[d][r] = '0;
      end
    end
    repeat (3) @(negedge clk);
    chk("reset_grant", 0, 32'(grant[0]), 32'd0);
    chk("reset_cyc",   0, 32'(spi_cyc[0]), 32'd0);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    // CPU-only read, slave acks after 5 cycles
    slave_lat[0] = 5; slave_data[0] = 32'hDEAD_BEEF;
    access(0, 0, 32'h0000_0100, 32'h0, 1'b0, 1'b0);
    chk("t1_rdt",    0, r_rdt[0][0], 32'hDEAD_BEEF);
    chk("t1_grant",  0, 32'(lg_grant[0][0]), 32'd1);
    chk("t1_adr",    0, lg_adr[0][0], 32'h0000_0100);
    chk("t1_cyclen", 0, 32'(last_run[0]), 32'd5);
    chk("t1_auxack", 0, 32'(ack_cnt[0][1]), 32'd0);
    @(posedge clk); #2;
    chk("t1_grant_after", 0, 32'(grant[0]), 32'd0);

    // Simultaneous cpu read + aux write from reset, twice
    apply_reset(0);
    slave_lat[0] = 3; slave_data[0] = 32'hA5A5_0001;
    base = log_n[0];
    for (int k = 0; k < 2; k++) begin
      fork
        access(0, 0, 32'h0000_0200, 32'h0, 1'b0, 1'b0);
        access(0, 1, 32'h0000_0300, 32'h1234_5678, 1'b1, 1'b0);
      join
    end
    chk("t2_g0", 0, 32'(lg_grant[0][base]),     32'd1);
    chk("t2_g1", 0, 32'(lg_grant[0][base + 1]), 32'd2);
    chk("t2_g2", 0, 32'(lg_grant[0][base + 2]), 32'd1);
    chk("t2_g3", 0, 32'(lg_grant[0][base + 3]), 32'd2);
    chk("t2_we", 0, 32'(lg_we[0][base + 1]),    32'd1);
    chk("t2_dat", 0, lg_dat[0][base + 1],       32'h1234_5678);
    chk("t2_cpu_rdt", 0, r_rdt[0][0], 32'hA5A5_0001);

    // Ack arrives in the same cycle the counter expires: real data, no timeout
    slave_lat[0] = TO; slave_data[0] = 32'h0BAD_F00D;
    access(0, 0, 32'h0000_0400, 32'h0, 1'b0, 1'b0);
    chk("t3_rdt",     0, r_rdt[0][0], 32'h0BAD_F00D);
    chk("t3_timeout", 0, 32'(tflag[0]), 32'd0);
    chk("t3_cyclen",  0, 32'(last_run[0]), 32'(TO));

    // Slave never acks: abort after TIMEOUT cycles, then a late ack is ignored
    slave_lat[0] = 0; slave_data[0] = 32'h5555_5555;
    access(0, 0, 32'h0000_0500, 32'h0, 1'b0, 1'b0);
    chk("t4_rdt",     0, r_rdt[0][0], 32'hFFFF_FFFF);
    chk("t4_timeout", 0, 32'(tflag[0]), 32'd1);
    chk("t4_cyclen",  0, 32'(last_run[0]), 32'(TO));
    acks = ack_cnt[0][0] + ack_cnt[0][1];
    repeat (3) @(negedge clk);
    extra_ack[0] = 1'b1;
    @(negedge clk);
    extra_ack[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_late_ack", 0, 32'(ack_cnt[0][0] + ack_cnt[0][1] - acks), 32'd0);
    slave_lat[0] = 2; slave_data[0] = 32'h600D_CAFE;
    access(0, 0, 32'h0000_0600, 32'h0, 1'b0, 1'b0);
    chk("t4_next_rdt", 0, r_rdt[0][0], 32'h600D_CAFE);
    chk("t4_sticky",   0, 32'(tflag[0]), 32'd1);

    // Reset in the middle of an active transfer
    slave_lat[0] = 0;
    @(negedge clk);
    r_adr[0][0] = 32'h0000_0700; r_we[0][0] = 1'b0; r_cyc[0][0] = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_active", 0, 32'(spi_cyc[0]), 32'd1);
    acks = ack_cnt[0][0] + ack_cnt[0][1];
    rst_n[0] = 1'b0;
    @(posedge clk); #2;
    chk("t5_cyc",     0, 32'(spi_cyc[0]), 32'd0);
    chk("t5_grant",   0, 32'(grant[0]), 32'd0);
    chk("t5_rdt",     0, r_rdt[0][0], 32'd0);
    chk("t5_timeout", 0, 32'(tflag[0]), 32'd0);
    chk("t5_adr",     0, spi_adr[0], 32'd0);
    @(negedge clk);
    r_cyc[0][0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n[0] = 1'b1;
    chk("t5_no_ack", 0, 32'(ack_cnt[0][0] + ack_cnt[0][1] - acks), 32'd0);
    slave_lat[0] = 2; slave_data[0] = 32'h1357_9BDF;
    access(0, 0, 32'h0000_0800, 32'h0, 1'b0, 1'b0);
    chk("t5_after_rdt", 0, r_rdt[0][0], 32'h1357_9BDF);

    // Fixed priority: cpu holds cyc across three accesses while aux waits
    slave_lat[1] = 2; slave_data[1] = 32'hC0DE_0001;
    base = log_n[1];
    fork
      begin
        access(1, 0, 32'h0000_0010, 32'h0, 1'b0, 1'b1);
        access(1, 0, 32'h0000_0014, 32'h0, 1'b0, 1'b1);
        access(1, 0, 32'h0000_0018, 32'h0, 1'b0, 1'b0);
      end
      access(1, 1, 32'h0000_0020, 32'hFACE_0000, 1'b1, 1'b0);
    join
    chk("t6_g0", 1, 32'(lg_grant[1][base]),     32'd1);
    chk("t6_g1", 1, 32'(lg_grant[1][base + 1]), 32'd1);
    chk("t6_g2", 1, 32'(lg_grant[1][base + 2]), 32'd1);
    chk("t6_g3", 1, 32'(lg_grant[1][base + 3]), 32'd2);
    chk("t6_a1", 1, lg_adr[1][base + 1], 32'h0000_0014);
    chk("t6_a3", 1, lg_adr[1][base + 3], 32'h0000_0020);
    chk("t6_aux_rdt", 1, r_rdt[1][1], 32'hC0DE_0001);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
